mano_run_ctrl: RTL
==================

# mano_run_ctrl

Run/step/halt sequencer and memory-port owner for the Mano-style accumulator computer. Owns the 3-bit sequence counter and its one-hot timing outputs. Gates every datapath register enable through a single `cpu_en`. Multiplexes the single 16x8 RAM between the CPU datapath and an external program loader, which may write memory only while the CPU is halted. Sits between the top-level CPU and the control unit/RAM.

## Interface
Parameters:
- ADDR_W, 4, RAM address width
- DATA_W, 8, RAM/bus data width

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  synchronous, active-high reset
- run  in  1  request continuous execution (level, sampled in HALT)
- step  in  1  request exactly one instruction (sampled in HALT)
- halt_req  in  1  request stop at end of current instruction
- instr_done  in  1  control unit's CLRSC: last T-state of current instruction
- hlt_instr  in  1  decoded HLT opcode, qualified by instr_done
- cpu_we  in  1  CPU memory write strobe
- cpu_addr  in  ADDR_W  CPU memory address (AR)
- cpu_wdata  in  DATA_W  CPU write data (common bus)
- ld_req  in  1  loader write request
- ld_addr  in  ADDR_W  loader address
- ld_data  in  DATA_W  loader data
- ld_ack  out  1  loader write performed this cycle
- T  out  8  one-hot timing signal, T[n] = (SC == n)
- cpu_en  out  1  enable for all CPU register loads/increments
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_sel  out  1  1 = loader owns RAM
- state  out  2  HALT=00, RUN=01, STEP=10, LOAD=11
- instr_count  out  8  retired-instruction counter
- sc_err  out  1  sticky: SC overflow detected

## Operation
- States:
  - HALT: SC held at 0; cpu_en=0.
  - RUN/STEP: cpu_en=1; SC increments each cycle.
  - LOAD: one-cycle loader write.
- HALT transitions, priority ld_req > run > step:
  - ld_req -> LOAD; ld_addr/ld_data captured into holding registers on that edge.
  - run -> RUN.
  - step -> STEP.
- RUN:
  - halt_req sets a sticky pend_halt.
  - On instr_done: SC->0 and instr_count+1. Go to HALT if pend_halt, hlt_instr, or halt_req in that same cycle; otherwise stay in RUN.
  - pend_halt clears on entry to HALT.
  - ld_req ignored; ld_ack=0.
- STEP: as RUN, but always -> HALT on instr_done.
- LOAD:
  - mem_sel=1, mem_we=1, mem_addr/mem_wdata = captured values, ld_ack=1.
  - Next state HALT unconditionally.
  - A still-asserted ld_req starts another write, so sustained loading costs 2 cycles per word.
- Memory mux:
  - mem_sel=0: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=cpu_we & cpu_en.
- SC overflow: SC==7 with cpu_en=1 and no instr_done sets sc_err, forces SC->0 and state->HALT; no instr_count increment. sc_err clears only on RST.
- instr_count wraps 255->0.
- run/step while in RUN/STEP are ignored.

## Timing
- Reset values:
  - state=HALT, SC=0 (T=8'h01).
  - cpu_en=0, mem_sel=0, mem_we=0, ld_ack=0.
  - instr_count=0, sc_err=0, pend_halt=0.
  - mem_addr=cpu_addr, mem_wdata=cpu_wdata.
- RST high forces cpu_en=0 and mem_we=0 combinationally in that cycle. A LOAD or CPU write coinciding with RST is aborted.
- State, SC, and counters are registered. T, cpu_en, mem_*, and ld_ack decode combinationally from registered state and SC.
- run sampled at edge k: cycle k+1 is T0 with cpu_en=1. An instruction asserting instr_done in Tn retires at the edge ending Tn, taking n+1 cycles.
- Loader latency: ld_req sampled at edge k; the write and ld_ack occur in cycle k+1.

## Test plan
- Reset: RST 1 cycle -> state=00, T=8'h01, cpu_en=0, instr_count=0, mem_we=0 even with cpu_we=1.
- Load then run:
  - Stimulus: ld_req held with ld_addr=4'h3, ld_data=8'hA5.
  - Required: LOAD every other cycle; mem_we/ld_ack pulse with mem_addr=3, mem_wdata=A5.
  - Then run=1 (ld_req low) -> RUN; T sequences 01,02,04,08.
  - instr_done at T3 -> T=01 next; instr_count=1.
- Step: step pulse; instr_done at T4 -> exactly 5 cpu_en cycles, state back to 00, instr_count+1. ld_req during STEP gets no ack.
- Halt/HLT:
  - halt_req mid-instruction -> instruction completes, then HALT.
  - hlt_instr with instr_done -> HALT same edge.
  - Simultaneous ld_req+run in HALT -> LOAD first, then RUN.
- Overflow: RUN with instr_done never asserted -> after T7, sc_err=1, state=00, instr_count unchanged.
- Reset mid-operation: RST during LOAD -> no mem_we that cycle, state=00. RST during RUN at T2 -> T=01, cpu_en=0.

Source files
------------

// File: rtl/mano_run_ctrl.sv
// Run/step/halt sequencer for the Mano accumulator computer: owns the sequence
// counter, gates every datapath enable, and arbitrates the RAM with the loader.
module mano_run_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              run,
    input  logic              step,
    input  logic              halt_req,
    input  logic              instr_done,
    input  logic              hlt_instr,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ack,
    output logic [7:0]        T,
    output logic              cpu_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_sel,
    output logic [1:0]        state,
    output logic [7:0]        instr_count,
    output logic              sc_err
);

    // Handshake: the loader holds ld_req; each accepted word is acknowledged
    // by a single-cycle ld_ack in the LOAD cycle, which is also the RAM write.
    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_LOAD = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        sc_q, sc_d;
    logic [7:0]        instr_count_q, instr_count_d;
    logic              sc_err_q, sc_err_d;
    logic              pend_halt_q, pend_halt_d;
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic [DATA_W-1:0] ld_data_q, ld_data_d;

    logic executing;
    logic stop_now;

    assign executing = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign stop_now  = (state_q == ST_STEP) || pend_halt_q || hlt_instr || halt_req;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_HALT;
            sc_q          <= 3'd0;
            instr_count_q <= 8'd0;
            sc_err_q      <= 1'b0;
            pend_halt_q   <= 1'b0;
            ld_addr_q     <= '0;
            ld_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            sc_q          <= sc_d;
            instr_count_q <= instr_count_d;
            sc_err_q      <= sc_err_d;
            pend_halt_q   <= pend_halt_d;
            ld_addr_q     <= ld_addr_d;
            ld_data_q     <= ld_data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d       = state_q;
        sc_d          = sc_q;
        instr_count_d = instr_count_q;
        sc_err_d      = sc_err_q;
        pend_halt_d   = pend_halt_q;
        ld_addr_d     = ld_addr_q;
        ld_data_d     = ld_data_q;

        case (state_q)
            ST_HALT: begin
                sc_d        = 3'd0;
                pend_halt_d = 1'b0;
                if (ld_req) begin
                    state_d   = ST_LOAD;
                    ld_addr_d = ld_addr;
                    ld_data_d = ld_data;
                end else if (run) begin
                    state_d = ST_RUN;
                end else if (step) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN, ST_STEP: begin
                if (instr_done) begin
                    sc_d          = 3'd0;
                    instr_count_d = instr_count_q + 8'd1;
                    if (stop_now) begin
                        state_d     = ST_HALT;
                        pend_halt_d = 1'b0;
                    end
                end else if (sc_q == 3'd7) begin
                    // A runaway instruction never raised CLRSC: stop rather than wrap.
                    sc_err_d    = 1'b1;
                    sc_d        = 3'd0;
                    state_d     = ST_HALT;
                    pend_halt_d = 1'b0;
                end else begin
                    sc_d = sc_q + 3'd1;
                    if (halt_req) begin
                        pend_halt_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // Output decode; RST gates every write so a coinciding reset aborts it
    always_comb begin
        T         = 8'h00;
        T[sc_q]   = 1'b1;
        cpu_en    = executing && !RST;
        mem_sel   = (state_q == ST_LOAD) && !RST;
        ld_ack    = mem_sel;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we && cpu_en;
        if (mem_sel) begin
            mem_addr  = ld_addr_q;
            mem_wdata = ld_data_q;
            mem_we    = 1'b1;
        end
    end

    assign state       = state_q;
    assign instr_count = instr_count_q;
    assign sc_err      = sc_err_q;

endmodule
